// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT sequencing blocks.
// Holds the controller FSM state encoding and a bit-reversal helper.
// Purely declarative: no logic, no ports, no clocked behaviour.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    UNLOAD = 3'd3,
    DONE   = 3'd4
  } fsm_state_e;

  // Reverse the low w bits of v; bits above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = {<<{v}};
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/fft_dif_ctrl_addr_gen.sv
// fft_addr_gen: butterfly operand and twiddle address generator for radix-2 DIF.
// Latency: purely combinational, outputs follow (k, s) in the same cycle.
// Backpressure: none; the caller decides when k and s advance.
// Ports: k (butterfly index within the stage), s (stage index) -> a, b (operand
// pair addresses, b = a + span) and tw (twiddle ROM address).
module fft_addr_gen #(
  parameter int N_POINTS = 16,
  localparam int ADDRW = $clog2(N_POINTS),
  localparam int TWW = ADDRW - 1,
  localparam int STGW = (ADDRW > 1) ? $clog2(ADDRW) : 1
) (
  input  logic [TWW-1:0]   k,
  input  logic [STGW-1:0]  s,
  output logic [ADDRW-1:0] a,
  output logic [ADDRW-1:0] b,
  output logic [TWW-1:0]   tw
);

  logic [ADDRW-1:0] span;
  logic [ADDRW-1:0] mask;
  logic [ADDRW-1:0] kx;
  logic [ADDRW-1:0] j;

  // span is a power of two, so k mod span and k / span reduce to masking;
  // doubling the group bits of k yields g*2*span directly.
  always_comb begin
    span = ADDRW'(N_POINTS / 2) >> s;
    mask = span - ADDRW'(1);
    kx   = ADDRW'(k);
    j    = kx & mask;
    a    = ((kx & ~mask) << 1) | j;
    b    = a | span;
    tw   = TWW'(j << s);
  end

endmodule

// File: rtl/fft_dif_ctrl.sv
// fft_dif_ctrl: stage/butterfly sequencer for an in-place radix-2 DIF FFT.
// Latency: start -> first rd_en 1 cycle; write-back trails reads by BFU_LAT cycles;
//          done after log2(N)*(N/2+BFU_LAT)+1 cycles (+N with bit-reversed unload).
// Backpressure: hold freezes FSM, counters and write pipeline; strobes keep their values.
// Ports: start/busy/done handshake; rd_en, rd_addr_a/b, tw_addr for operand fetch;
// wr_en, wr_addr_a/b for write-back; stage index. Optional FFT_CTRL_BITREV_EN adds
// an UNLOAD phase with out_valid/out_addr presenting results in natural order.
module fft_dif_ctrl
  import fft_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int BFU_LAT = 2,
  localparam int ADDRW = $clog2(N_POINTS),
  localparam int TWW = ADDRW - 1,
  localparam int STGW = (ADDRW > 1) ? $clog2(ADDRW) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [STGW-1:0]  stage,
  output logic             rd_en,
  output logic [ADDRW-1:0] rd_addr_a,
  output logic [ADDRW-1:0] rd_addr_b,
  output logic [TWW-1:0]   tw_addr,
  output logic             wr_en,
  output logic [ADDRW-1:0] wr_addr_a,
  output logic [ADDRW-1:0] wr_addr_b
`ifdef FFT_CTRL_BITREV_EN
  ,
  output logic             out_valid,
  output logic [ADDRW-1:0] out_addr
`endif
);

  localparam int LATW = (BFU_LAT > 1) ? $clog2(BFU_LAT) : 1;
  localparam logic [TWW-1:0]  K_LAST   = TWW'(N_POINTS / 2 - 1);
  localparam logic [STGW-1:0] S_LAST   = STGW'(ADDRW - 1);
  localparam logic [LATW-1:0] LAT_LAST = LATW'(BFU_LAT - 1);

  fsm_state_e      state_q, state_d;
  logic [TWW-1:0]  k_q, k_d;
  logic [STGW-1:0] stage_q, stage_d;
  logic [LATW-1:0] dcnt_q, dcnt_d;
`ifdef FFT_CTRL_BITREV_EN
  logic [ADDRW-1:0] uidx_q, uidx_d;
`endif

  // Write-back delay line; index BFU_LAT-1 is the oldest entry.
  logic [BFU_LAT-1:0]            wen_q, wen_d;
  logic [BFU_LAT-1:0][ADDRW-1:0] wa_q, wa_d;
  logic [BFU_LAT-1:0][ADDRW-1:0] wb_q, wb_d;

  logic [ADDRW-1:0] gen_a;
  logic [ADDRW-1:0] gen_b;
  logic [TWW-1:0]   gen_tw;

  fft_addr_gen #(
    .N_POINTS(N_POINTS)
  ) u_addr_gen (
    .k (k_q),
    .s (stage_q),
    .a (gen_a),
    .b (gen_b),
    .tw(gen_tw)
  );

  // Next-state and counter logic; everything holds while hold is high.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
`ifdef FFT_CTRL_BITREV_EN
    uidx_d  = uidx_q;
`endif
    if (!hold) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            k_d     = '0;
            stage_d = '0;
          end
        end
        RUN: begin
          if (k_q == K_LAST) begin
            state_d = DRAIN;
            k_d     = '0;
            dcnt_d  = '0;
          end else begin
            k_d = k_q + TWW'(1);
          end
        end
        DRAIN: begin
          // Stay until the last butterfly of the stage has been written back.
          if (dcnt_q == LAT_LAST) begin
            dcnt_d = '0;
            if (stage_q == S_LAST) begin
`ifdef FFT_CTRL_BITREV_EN
              state_d = UNLOAD;
              uidx_d  = '0;
`else
              state_d = DONE;
`endif
            end else begin
              state_d = RUN;
              stage_d = stage_q + STGW'(1);
            end
          end else begin
            dcnt_d = dcnt_q + LATW'(1);
          end
        end
`ifdef FFT_CTRL_BITREV_EN
        UNLOAD: begin
          if (uidx_q == ADDRW'(N_POINTS - 1)) begin
            state_d = DONE;
            uidx_d  = '0;
          end else begin
            uidx_d = uidx_q + ADDRW'(1);
          end
        end
`endif
        DONE: begin
          state_d = IDLE;
          stage_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Read-side outputs decode straight from state so reset clears them at once.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    rd_en     = (state_q == RUN);
    rd_addr_a = rd_en ? gen_a : '0;
    rd_addr_b = rd_en ? gen_b : '0;
    tw_addr   = rd_en ? gen_tw : '0;
  end

  assign stage = stage_q;

`ifdef FFT_CTRL_BITREV_EN
  always_comb begin
    out_valid = (state_q == UNLOAD);
    out_addr  = out_valid ? ADDRW'(bitrev(32'(uidx_q), ADDRW)) : '0;
  end
`endif

  // Shift the read strobe and addresses in at index 0; the cast drops the oldest.
  always_comb begin
    wen_d = wen_q;
    wa_d  = wa_q;
    wb_d  = wb_q;
    if (!hold) begin
      wen_d = BFU_LAT'({wen_q, rd_en});
      wa_d  = (BFU_LAT * ADDRW)'({wa_q, rd_addr_a});
      wb_d  = (BFU_LAT * ADDRW)'({wb_q, rd_addr_b});
    end
  end

  assign wr_en     = wen_q[BFU_LAT-1];
  assign wr_addr_a = wa_q[BFU_LAT-1];
  assign wr_addr_b = wb_q[BFU_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      dcnt_q  <= '0;
`ifdef FFT_CTRL_BITREV_EN
      uidx_q  <= '0;
`endif
      wen_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
`ifdef FFT_CTRL_BITREV_EN
      uidx_q  <= uidx_d;
`endif
      wen_q   <= wen_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
    end
  end

endmodule

// File: tb/tb_fft_dif_ctrl.sv
// Directed bench for fft_dif_ctrl with N_POINTS=8, BFU_LAT=2.
// Expected butterfly triples are a hand-computed table; cycle numbers count
// from the start-sampling edge (cycle 1 is the period right after it).
module tb_fft_dif_ctrl;

  localparam int N = 8;
  localparam int LAT = 2;
`ifdef FFT_CTRL_BITREV_EN
  localparam int EXTRA = 8;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       hold;
  logic       busy;
  logic       done;
  logic [1:0] stage;
  logic       rd_en;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [1:0] tw_addr;
  logic       wr_en;
  logic [2:0] wr_addr_a;
  logic [2:0] wr_addr_b;
`ifdef FFT_CTRL_BITREV_EN
  logic       out_valid;
  logic [2:0] out_addr;
`endif

  fft_dif_ctrl #(
    .N_POINTS(N),
    .BFU_LAT (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hold     (hold),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr  (tw_addr),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b)
`ifdef FFT_CTRL_BITREV_EN
    ,
    .out_valid(out_valid),
    .out_addr (out_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int tw;
  } vec_t;

  vec_t tbl[12];
  int   exp_out[8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Runs one transform from a start pulse; optional 3-cycle hold from cycle
  // hold_at and an ignored start re-pulse in cycle restart_at.
  task automatic run_scn(input string nm, input int hold_at, input int restart_at,
                         input int exp_done);
    int rd_i = 0;
    int wr_i = 0;
    int oi = 0;
    int ndone = 0;
    int done_cyc = 0;
    int base;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      hold  = (hold_at > 0) && (cyc >= hold_at) && (cyc < hold_at + 3);
      start = (cyc == restart_at);
      #2;
      if (rd_en && !hold) begin
        if (rd_i < 12) begin
          chk({nm, " rd_a"}, int'(rd_addr_a), tbl[rd_i].a);
          chk({nm, " rd_b"}, int'(rd_addr_b), tbl[rd_i].b);
          chk({nm, " tw"}, int'(tw_addr), tbl[rd_i].tw);
          chk({nm, " stage"}, int'(stage), rd_i / 4);
          chk({nm, " busy_run"}, int'(busy), 1);
          if (rd_i % 4 == 0) begin
            base = 1 + 6 * (rd_i / 4);
            if (hold_at > 0 && base > hold_at) base += 3;
            chk({nm, " stage_start_cyc"}, cyc, base);
          end
        end
        rd_i++;
      end
      if (!rd_en) chk({nm, " idle_addr"}, int'({rd_addr_a, rd_addr_b, tw_addr}), 0);
      if (wr_en && !hold) begin
        if (wr_i < 12) begin
          chk({nm, " wr_a"}, int'(wr_addr_a), tbl[wr_i].a);
          chk({nm, " wr_b"}, int'(wr_addr_b), tbl[wr_i].b);
          if (wr_i == 0) chk({nm, " first_wr_cyc"}, cyc, 3);
        end
        wr_i++;
      end
`ifdef FFT_CTRL_BITREV_EN
      if (out_valid && !hold) begin
        if (oi < 8) chk({nm, " out_addr"}, int'(out_addr), exp_out[oi]);
        if (oi == 0) chk({nm, " first_out_cyc"}, cyc, exp_done - 8);
        oi++;
      end
`endif
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    chk({nm, " rd_count"}, rd_i, 12);
    chk({nm, " wr_count"}, wr_i, 12);
    chk({nm, " done_count"}, ndone, 1);
    chk({nm, " done_cyc"}, done_cyc, exp_done);
    chk({nm, " busy_end"}, int'(busy), 0);
`ifdef FFT_CTRL_BITREV_EN
    chk({nm, " out_count"}, oi, 8);
`else
    chk({nm, " out_count"}, oi, 0);
`endif
  endtask

  initial begin
    tbl[0]  = '{0, 4, 0}; tbl[1]  = '{1, 5, 1}; tbl[2]  = '{2, 6, 2}; tbl[3]  = '{3, 7, 3};
    tbl[4]  = '{0, 2, 0}; tbl[5]  = '{1, 3, 2}; tbl[6]  = '{4, 6, 0}; tbl[7]  = '{5, 7, 2};
    tbl[8]  = '{0, 1, 0}; tbl[9]  = '{2, 3, 0}; tbl[10] = '{4, 5, 0}; tbl[11] = '{6, 7, 0};
    exp_out = '{0, 4, 2, 6, 1, 5, 3, 7};

    rst   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    #12;
    chk("reset_outputs", int'({busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                               wr_en, wr_addr_a, wr_addr_b}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // start coincident with hold must not launch a transform
    start = 1'b1;
    hold  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hold = 1'b0;
    #2 chk("start_with_hold_busy", int'(busy), 0);
    @(posedge clk);
    #3 chk("start_with_hold_rd_en", int'(rd_en), 0);

    run_scn("basic", 0, 0, 19 + EXTRA);
    run_scn("hold", 9, 0, 22 + EXTRA);
    run_scn("restart_busy", 0, 5, 19 + EXTRA);

    // asynchronous reset mid-stage-1
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outputs", int'({busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                                   wr_en, wr_addr_a, wr_addr_b}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #3;
      chk("post_rst_quiet", int'({busy, done, rd_en, wr_en}), 0);
    end
    #1;
    run_scn("after_rst", 0, 0, 19 + EXTRA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_dif_ctrl.md
# fft_dif_ctrl

Sequencing controller for the in-place radix-2 decimation-in-frequency FFT. For each stage it issues one butterfly per cycle, generating the operand-pair read addresses for the data memory and the twiddle-ROM address (driving `rom_async.addr` directly). It also delays the addresses to match the butterfly-unit pipeline so results are written back in place. The block sits between the top-level start/done interface, the data RAM, the twiddle ROM and the BFU.

## Interface
- `N_POINTS`, 16: transform size; power of two, ≥4.
- `BFU_LAT`, 2: cycles from operand read (`rd_en`) to BFU result valid for write-back; ≥1.
- Derived localparams: `ADDRW = $clog2(N_POINTS)`, `TWW = ADDRW-1`, `STGW = $clog2(ADDRW)` (min 1).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin transform; sampled only in IDLE.
- `hold`  in  1  global stall; freezes all state and pipelines while high.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at completion.
- `stage`  out  STGW  current stage index.
- `rd_en`  out  1  operand read strobe.
- `rd_addr_a`  out  ADDRW  upper operand address.
- `rd_addr_b`  out  ADDRW  lower operand address.
- `tw_addr`  out  TWW  twiddle ROM address, valid with `rd_en`.
- `wr_en`  out  1  result write strobe.
- `wr_addr_a`  out  ADDRW  upper result address.
- `wr_addr_b`  out  ADDRW  lower result address.
- `out_valid`  out  1  unload strobe; present only with `FFT_CTRL_BITREV_EN`.
- `out_addr`  out  ADDRW  bit-reversed unload address; present only with `FFT_CTRL_BITREV_EN`.

## Operation
- Decided: one clock, `clk`; reset `rst` is asynchronous and active-high.
- Reset value of every output is 0; state is IDLE, all counters and pipelines are 0.
- States:
  - IDLE → RUN on `start`.
  - RUN: issue butterfly k = 0..N/2-1, one per cycle; after k = N/2-1 → DRAIN.
  - DRAIN: wait exactly `BFU_LAT` cycles. Then → RUN with stage+1 if not the last stage; else → UNLOAD (macro) or DONE.
  - UNLOAD: i = 0..N-1, one per cycle, then → DONE.
  - DONE: asserts `done` for one cycle, then → IDLE.
- Address arithmetic for stage s, with span = N>>(s+1), j = k mod span, g = k / span:
  - a = g·2·span + j
  - b = a + span
  - tw = j << s
  - All values are unsigned and exact within their widths; no wrap is possible.
- Write-back: `wr_en`, `wr_addr_a` and `wr_addr_b` equal `rd_en`, `rd_addr_a` and `rd_addr_b` delayed by `BFU_LAT` enabled cycles. This is a shift register, cleared by reset.
- In RUN, `rd_en` = 1 and the address outputs carry the current k. Otherwise `rd_en` = 0; `rd_addr_a`, `rd_addr_b` and `tw_addr` then hold 0.
- `start` while `busy` is ignored. `start` coincident with `hold` is ignored.
- `hold` high: the FSM, counters and write pipeline do not advance; the strobes keep their values. The BFU must freeze on the same signal.
- `rst` asserted mid-transform returns the block to IDLE immediately; no `done` pulse is produced.

## Timing
- `start` sampled at edge 0 → first `rd_en` in cycle 1.
- Each stage takes N/2 + `BFU_LAT` cycles.
- DRAIN guarantees the last write of stage s (cycle t) precedes the first read of stage s+1 (cycle t+1). This requires synchronous RAM writes.
- Total latency from `start` to `done`: log2(N)·(N/2+`BFU_LAT`) + 1 cycles, plus N cycles with the macro. Stall cycles add one-for-one.

## Configuration
- `FFT_CTRL_BITREV_EN` defined:
  - The UNLOAD state and the `out_valid` / `out_addr` ports exist.
  - `out_addr` = bit-reverse(i, ADDRW), presenting results in natural order.
- Not defined: no UNLOAD state and no extra ports; DONE follows the last DRAIN directly.

## Structure
- Package `fft_pkg`:
  - FSM state enum (IDLE, RUN, DRAIN, UNLOAD, DONE).
  - `bitrev` function.
- Sub-module `fft_addr_gen`: combinational k, s → a, b, tw. It is reusable by a future radix-4 or DIT controller.
- The delay line is inline in `fft_dif_ctrl`.

## Test plan
- Stage 0, N=8, `BFU_LAT`=2: pulse `start` → cycles 1–4 give (a,b,tw) = (0,4,0), (1,5,1), (2,6,2), (3,7,3); `wr_en` high in cycles 3–6 with the same pairs.
- Stage 1 (cycles 7–10): (0,2,0), (1,3,2), (4,6,0), (5,7,2). Stage 2 (cycles 13–16): (0,1,0), (2,3,0), (4,5,0), (6,7,0). `done` pulses in cycle 19 (no macro).
- `hold` high for 3 cycles during stage 1, k=2 → all sequences shift by 3 and none is skipped or duplicated; `done` in cycle 22.
- `rst` asserted in cycle 9 → all outputs 0 asynchronously; no `done`. A new `start` then restarts from stage 0, k=0.
- `start` re-pulsed in cycle 5 while busy → ignored; the sequence is identical to the first scenario.
- With `FFT_CTRL_BITREV_EN`, N=8: `out_addr` in cycles 19–26 = 0, 4, 2, 6, 1, 5, 3, 7; `done` in cycle 27.
